// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch sequencer: owns the fetch PC, runs one imem request at a
// time, buffers the returned word for IF/ID, applies stalls and redirects.
//
// Ports:
//   clk, reset (async, active-low)
//   stall_d              decode cannot accept; hold fetch buffer
//   redirect_valid/pc    EX-taken branch/jump target
//   imem_req/addr        request to instruction memory
//   imem_ready/rdata     request completes, word valid
//   fetch_valid/pc/instr buffered instruction for IF/ID
//   flush_ifid           one-cycle pulse after a redirect
//   stall_f              no new request launched this cycle
//   fetch_err            sticky: a request waited MAX_WAIT cycles

module if_fetch_ctrl #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     MAX_WAIT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_d,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic            fetch_valid,
  output logic [XLEN-1:0] fetch_pc,
  output logic [31:0]     fetch_instr,
  output logic            flush_ifid,
  output logic            stall_f,
  output logic            fetch_err
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    DRAIN
  } state_e;

  localparam logic [7:0] WMAX = 8'(MAX_WAIT);

  state_e          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] drain_addr;
  logic [XLEN-1:0] tgt;
  logic            live;
  logic [7:0]      wait_cnt;

  logic req;
  logic launch;
  logic done;
  logic room;
  logic consume;

  // Buffer is free, or its word leaves for decode this cycle.
  assign room    = ~fetch_valid | ~stall_d;
  assign consume = fetch_valid & ~stall_d;
  assign tgt     = redirect_pc & ~XLEN'(3);

  // A request is only launched when its word has somewhere to go, so a
  // completion never lands on an unconsumed buffer. Once presented
  // (live) it stays up until ready, whatever stall_d does.
  always_comb begin
    req    = 1'b0;
    launch = 1'b0;
    unique case (state)
      FETCH: begin
        req    = live | room;
        launch = ~live & room;
      end
      HOLD: begin
        req    = room;
        launch = room;
      end
      DRAIN: req = 1'b1;
      default: ;
    endcase
  end

  assign done      = req & imem_ready;
  assign imem_req  = req;
  assign imem_addr = (state == DRAIN) ? drain_addr : pc;
  assign stall_f   = ~launch;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      drain_addr  <= RESET_PC;
      live        <= 1'b0;
      wait_cnt    <= '0;
      fetch_valid <= 1'b0;
      fetch_pc    <= '0;
      fetch_instr <= '0;
      flush_ifid  <= 1'b0;
      fetch_err   <= 1'b0;
    end else begin
      flush_ifid <= redirect_valid;

      if (done) begin
        wait_cnt <= '0;
      end else if (req && wait_cnt != WMAX) begin
        wait_cnt <= wait_cnt + 8'd1;
      end

      if (req && !imem_ready && wait_cnt == WMAX - 8'd1) begin
        fetch_err <= 1'b1;
      end

      if (consume) begin
        fetch_valid <= 1'b0;
      end

      if (redirect_valid) begin
        pc          <= tgt;
        fetch_valid <= 1'b0;
        live        <= 1'b0;
        // An unanswered request must stay on the bus; its data is dropped.
        if (req && !imem_ready) begin
          state      <= DRAIN;
          drain_addr <= imem_addr;
        end else begin
          state <= FETCH;
        end
      end else begin
        unique case (state)
          IDLE: state <= FETCH;
          FETCH, HOLD: begin
            if (done) begin
              fetch_valid <= 1'b1;
              fetch_pc    <= pc;
              fetch_instr <= imem_rdata;
              pc          <= pc + XLEN'(4);
              live        <= 1'b0;
              state       <= FETCH;
            end else if (req) begin
              live  <= 1'b1;
              state <= FETCH;
            end else begin
              state <= HOLD;
            end
          end
          DRAIN: begin
            if (imem_ready) begin
              state <= FETCH;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
